// File: rtl/axilite_slave_regs.sv
// +--------------------------------------------------------------------------+
// | axilite_slave_regs: AXI-Lite responder over NUM_REGS 32-bit registers,   |
// | exposed as a flat bus with a one-cycle write strobe.   Rev 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module axilite_slave_regs #(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [1:0]               BRESP,
  input  logic [31:0]              ARADDR,
  input  logic                     ARVALID,
  output logic                     ARREADY,
  output logic [31:0]              RDATA,
  output logic                     RVALID,
  input  logic                     RREADY,
  output logic [1:0]               RRESP,
  output logic [32*NUM_REGS-1:0]   regs_out,
  output logic                     wr_pulse,
  output logic [5:0]               wr_index
);

  localparam logic [31:0] c_NUM_REGS = 32'(NUM_REGS);
  localparam logic [1:0]  c_OKAY     = 2'b00;
  localparam logic [1:0]  c_SLVERR   = 2'b10;

  logic        r_rst_done;
  logic        r_aw_held;
  logic [31:0] r_aw_addr;
  logic        r_w_held;
  logic [31:0] r_w_data;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] r_regs [NUM_REGS];
  logic        r_wr_pulse;
  logic [5:0]  r_wr_index;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic [31:0] w_aw_off;
  logic        w_aw_ok;
  logic [5:0]  w_aw_idx;
  logic [31:0] w_ar_off;
  logic        w_ar_ok;
  logic [5:0]  w_ar_idx;
  logic [31:0] w_ar_data;

  // Readies stay low until the first edge after reset is released.
  assign AWREADY  = r_rst_done & ~r_aw_held & ~r_bvalid;
  assign WREADY   = r_rst_done & ~r_w_held & ~r_bvalid;
  assign ARREADY  = r_rst_done & ~r_rvalid;

  assign w_aw_hs  = AWVALID & AWREADY;
  assign w_w_hs   = WVALID & WREADY;
  assign w_ar_hs  = ARVALID & ARREADY;
  assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

  // BASE_ADDR is word aligned, so offset[1:0] equals addr[1:0].
  assign w_aw_off = r_aw_addr - BASE_ADDR;
  assign w_aw_ok  = (r_aw_addr >= BASE_ADDR) && (w_aw_off[1:0] == 2'b00) &&
                    ((w_aw_off >> 2) < c_NUM_REGS);
  assign w_aw_idx = w_aw_off[7:2];

  assign w_ar_off = ARADDR - BASE_ADDR;
  assign w_ar_ok  = (ARADDR >= BASE_ADDR) && (w_ar_off[1:0] == 2'b00) &&
                    ((w_ar_off >> 2) < c_NUM_REGS);
  assign w_ar_idx = w_ar_off[7:2];

  always_comb begin
    w_ar_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == 6'(i)) w_ar_data = r_regs[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_done <= 1'b0;
      r_aw_held  <= 1'b0;
      r_aw_addr  <= '0;
      r_w_held   <= 1'b0;
      r_w_data   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= c_OKAY;
      r_wr_pulse <= 1'b0;
      r_wr_index <= '0;
    end else begin
      r_rst_done <= 1'b1;
      r_wr_pulse <= w_commit & w_aw_ok;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= WDATA;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_aw_ok ? c_OKAY : c_SLVERR;
        if (w_aw_ok) r_wr_index <= w_aw_idx;
      end else if (r_bvalid && BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_commit && w_aw_ok && (w_aw_idx == 6'(i))) r_regs[i] <= r_w_data;
      end
    end
  end

  // A read sampled on the commit edge sees the pre-commit register value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= c_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_ar_ok ? w_ar_data : 32'h0;
      r_rresp  <= w_ar_ok ? c_OKAY : c_SLVERR;
    end else if (r_rvalid && RREADY) begin
      r_rvalid <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_out[32*gi +: 32] = r_regs[gi];
  end

  assign BVALID   = r_bvalid;
  assign BRESP    = r_bresp;
  assign RVALID   = r_rvalid;
  assign RDATA    = r_rdata;
  assign RRESP    = r_rresp;
  assign wr_pulse = r_wr_pulse;
  assign wr_index = r_wr_index;

endmodule

`default_nettype wire

// File: tb/tb_axilite_slave_regs.sv
// +--------------------------------------------------------------------------+
// | tb_axilite_slave_regs: scoreboard bench for axilite_slave_regs.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axilite_slave_regs;

  localparam int          NUM_REGS = 16;
  localparam logic [31:0] BASE     = 32'h4000_0000;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic [31:0]            AWADDR = '0;
  logic                   AWVALID = 1'b0;
  logic                   AWREADY;
  logic [31:0]            WDATA = '0;
  logic                   WVALID = 1'b0;
  logic                   WREADY;
  logic                   BVALID;
  logic                   BREADY = 1'b1;
  logic [1:0]             BRESP;
  logic [31:0]            ARADDR = '0;
  logic                   ARVALID = 1'b0;
  logic                   ARREADY;
  logic [31:0]            RDATA;
  logic                   RVALID;
  logic                   RREADY = 1'b1;
  logic [1:0]             RRESP;
  logic [32*NUM_REGS-1:0] regs_out;
  logic                   wr_pulse;
  logic [5:0]             wr_index;

  axilite_slave_regs #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .wr_index(wr_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          errors = 0;
  int          checks = 0;
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [5:0]  wq[$];
  logic [31:0] model [NUM_REGS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every response handshake and strobe must match a queued expectation.
  always @(negedge clk) begin
    if (reset_n) begin
      if (BVALID && BREADY) begin
        if (bq.size() == 0) flag("b_unexpected");
        else chk("bresp", BRESP, bq.pop_front());
      end
      if (RVALID && RREADY) begin
        if (rq.size() == 0) flag("r_unexpected");
        else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rdata", RDATA, e.data);
          chk("rresp", RRESP, e.resp);
        end
      end
      if (wr_pulse) begin
        if (wq.size() == 0) flag("wr_pulse_unexpected");
        else chk("wr_index", wr_index, wq.pop_front());
      end
    end
  end

  // Channel drivers: called at a negedge; return at the negedge after the handshake edge.
  task automatic send_aw(input logic [31:0] a);
    AWADDR = a; AWVALID = 1'b1;
    for (int n = 0; n < 50 && !AWREADY; n++) @(negedge clk);
    if (!AWREADY) flag("aw_timeout");
    @(negedge clk);
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d);
    WDATA = d; WVALID = 1'b1;
    for (int n = 0; n < 50 && !WREADY; n++) @(negedge clk);
    if (!WREADY) flag("w_timeout");
    @(negedge clk);
    WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    ARADDR = a; ARVALID = 1'b1;
    for (int n = 0; n < 50 && !ARREADY; n++) @(negedge clk);
    if (!ARREADY) flag("ar_timeout");
    @(negedge clk);
    ARVALID = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input bit ok);
    logic [31:0] off;
    off = a - BASE;
    bq.push_back(ok ? 2'b00 : 2'b10);
    if (ok) begin
      wq.push_back(off[7:2]);
      model[off[7:2]] = d;
    end
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input bit ok);
    expect_write(a, d, ok);
    fork
      send_aw(a);
      send_w(d);
    join
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    rexp_t e;
    e.data = d; e.resp = r;
    rq.push_back(e);
    send_ar(a);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50; n++) begin
      if (bq.size() == 0 && rq.size() == 0 && wq.size() == 0 && !BVALID && !RVALID) return;
      @(negedge clk);
    end
    flag("idle_timeout");
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      chk($sformatf("%s_reg%0d", tag, i), regs_out[32*i +: 32], model[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", AWREADY, 1);
    chk("post_rst_wready", WREADY, 1);
    chk("post_rst_arready", ARREADY, 1);
    chk("post_rst_rdata", RDATA, 0);
    chk("post_rst_wr_index", wr_index, 0);
    chk_regs("post_rst");

    // AW and W together: BVALID one edge after the handshake edge
    issue_write(BASE + 8, 32'hDEAD_BEEF, 1);
    chk("t1_b_not_early", BVALID, 0);
    @(negedge clk);
    chk("t1_bvalid", BVALID, 1);
    chk("t1_wr_pulse", wr_pulse, 1);
    @(negedge clk);
    chk("t1_wr_pulse_once", wr_pulse, 0);
    wait_idle();
    chk("t1_reg2", regs_out[95:64], 32'hDEAD_BEEF);
    issue_read(BASE + 8, 32'hDEAD_BEEF, 2'b00);
    wait_idle();

    // W five cycles before AW
    expect_write(BASE + 4, 32'h1234_5678, 1);
    fork
      send_w(32'h1234_5678);
      begin
        repeat (5) @(negedge clk);
        chk("t2_wready_low", WREADY, 0);
        send_aw(BASE + 4);
        chk("t2_no_commit_yet", BVALID, 0);
        @(negedge clk);
        chk("t2_commit", BVALID, 1);
      end
    join
    wait_idle();
    chk("t2_reg1", regs_out[63:32], 32'h1234_5678);

    // AW five cycles before W
    expect_write(BASE + 4, 32'h8765_4321, 1);
    fork
      send_aw(BASE + 4);
      begin
        repeat (5) @(negedge clk);
        chk("t2b_awready_low", AWREADY, 0);
        send_w(32'h8765_4321);
        chk("t2b_no_commit_yet", BVALID, 0);
        @(negedge clk);
        chk("t2b_commit", BVALID, 1);
      end
    join
    wait_idle();
    chk("t2b_reg1", regs_out[63:32], 32'h8765_4321);

    // Decode errors and the last valid register
    issue_write(BASE + NUM_REGS * 4, 32'hBAD0_0001, 0);
    wait_idle();
    issue_write(BASE + 2, 32'hBAD0_0002, 0);
    wait_idle();
    issue_write(BASE - 4, 32'hBAD0_0003, 0);
    wait_idle();
    chk_regs("t3_err");
    issue_read(BASE + 32'h100, 32'h0, 2'b10);
    wait_idle();
    issue_write(BASE + 60, 32'hCAFE_0015, 1);
    wait_idle();
    issue_read(BASE + 60, 32'hCAFE_0015, 2'b00);
    wait_idle();

    // BREADY held low for 10 cycles with a second write waiting
    BREADY = 1'b0;
    issue_write(BASE + 20, 32'h5555_AAAA, 1);
    @(negedge clk);
    fork
      issue_write(BASE + 24, 32'h6666_7777, 1);
      begin
        for (int k = 0; k < 10; k++) begin
          chk("t4_bvalid_hold", BVALID, 1);
          chk("t4_bresp_hold", BRESP, 0);
          chk("t4_awready_low", AWREADY, 0);
          chk("t4_wready_low", WREADY, 0);
          @(negedge clk);
        end
        BREADY = 1'b1;
      end
    join
    wait_idle();
    chk_regs("t4");

    // Read and commit to reg3 on the same edge
    issue_write(BASE + 12, 32'h0000_0011, 1);
    wait_idle();
    expect_write(BASE + 12, 32'hA5A5_A5A5, 1);
    begin
      rexp_t e;
      e.data = 32'h0000_0011; e.resp = 2'b00;
      rq.push_back(e);
    end
    AWADDR = BASE + 12; WDATA = 32'hA5A5_A5A5; AWVALID = 1'b1; WVALID = 1'b1;
    chk("t5_awready", AWREADY, 1);
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = BASE + 12; ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    wait_idle();
    issue_read(BASE + 12, 32'hA5A5_A5A5, 2'b00);
    wait_idle();

    // Reset with AW held and a read response pending
    RREADY = 1'b0;
    AWADDR = BASE; AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    send_ar(BASE + 8);
    chk("t6_rvalid_pending", RVALID, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_awready", AWREADY, 0);
    chk("t6_wready", WREADY, 0);
    chk("t6_arready", ARREADY, 0);
    chk("t6_bvalid", BVALID, 0);
    chk("t6_rvalid", RVALID, 0);
    chk("t6_rdata", RDATA, 0);
    chk("t6_rresp", RRESP, 0);
    chk("t6_bresp", BRESP, 0);
    chk("t6_wr_pulse", wr_pulse, 0);
    chk("t6_wr_index", wr_index, 0);
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    chk_regs("t6_rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    RREADY = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_post_awready", AWREADY, 1);
    chk("t6_post_wready", WREADY, 1);
    chk("t6_post_arready", ARREADY, 1);
    chk("t6_post_bvalid", BVALID, 0);
    // The dropped AW must not pair with a fresh W
    expect_write(BASE + 4, 32'h0000_0077, 1);
    send_w(32'h0000_0077);
    repeat (3) begin
      @(negedge clk);
      chk("t6_w_alone_no_b", BVALID, 0);
    end
    send_aw(BASE + 4);
    wait_idle();
    chk_regs("t6_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axilite_slave_regs.md
Name: axilite_slave_regs

Overview:
AXI-Lite responder (slave) exposing a bank of NUM_REGS 32-bit read/write registers. It is the target side of the AXI-Lite master FSM, speaks the same AW/W/B/AR/R signal set, and adds BRESP and RRESP. Register contents are presented to local logic as a flat bus, with a one-cycle write strobe per committed write. Used as the control/status endpoint behind the master in bring-up and loopback configurations.

Parameters:
NUM_REGS, 16, number of 32-bit registers (2..64)
BASE_ADDR, 32'h0000_0000, byte address of register 0; must be 4-byte aligned

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
AWADDR  input  32  write address
AWVALID  input  1  write address valid
AWREADY  output  1  write address ready
WDATA  input  32  write data
WVALID  input  1  write data valid
WREADY  output  1  write data ready
BVALID  output  1  write response valid
BREADY  input  1  write response ready
BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR
ARADDR  input  32  read address
ARVALID  input  1  read address valid
ARREADY  output  1  read address ready
RDATA  output  32  read data
RVALID  output  1  read data valid
RREADY  input  1  read data ready
RRESP  output  2  read response: 2'b00 OKAY, 2'b10 SLVERR
regs_out  output  32*NUM_REGS  register contents; reg i is bits [32*i+31:32*i]
wr_pulse  output  1  one-cycle pulse on a successful register write
wr_index  output  6  index of the register written; valid while wr_pulse=1

Behaviour:
- Reset (async assert, sync release): all registers 0; AWREADY=WREADY=ARREADY=0 during reset, 1 in the first cycle after release; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0; wr_pulse=0; wr_index=0. Any in-flight transaction is dropped and its response is never issued.
- Address decode: offset = addr - BASE_ADDR. The address is valid when addr >= BASE_ADDR, addr[1:0]==0 and offset>>2 < NUM_REGS; index = offset>>2. Arithmetic is 32-bit unsigned.
- Write path. The AW and W captures are independent and may occur in either order or in the same cycle.
  - aw_held is set on AWVALID&AWREADY. AWREADY = !aw_held & !BVALID.
  - w_held is set on WVALID&WREADY. WREADY = !w_held & !BVALID.
  - Commit takes effect on the first rising edge at which aw_held & w_held = 1 and BVALID=0:
    - valid address: register[index] <= data; BRESP=00; wr_pulse=1 for exactly one cycle; wr_index=index.
    - invalid address: no register changes; BRESP=10; wr_pulse stays 0.
    - In both cases BVALID becomes 1 and aw_held and w_held clear.
  - Minimum latency: AW and W accepted at edge N, commit and BVALID at edge N+1.
  - BVALID holds with a stable BRESP until BVALID&BREADY. It clears on that edge, and AWREADY/WREADY return to 1 in the following cycle.
  - While one of AW/W is held, the other channel's VALID may stay low indefinitely. There is no timeout.
- Read path.
  - ARREADY = !RVALID.
  - On the ARVALID&ARREADY edge:
    - valid address: RDATA = register[index] (the value before any commit on that same edge); RRESP=00.
    - invalid address: RDATA=0; RRESP=10.
    - In both cases RVALID becomes 1.
  - RVALID, RDATA and RRESP hold until RVALID&RREADY. RVALID clears on that edge. ARREADY is 1 in the next cycle, so the maximum rate is one read per 2 cycles.
- Reads and writes are fully independent and may proceed concurrently. A read and a write commit to the same register on the same edge return the old value; the new value is visible to a read accepted on any later edge.
- regs_out reflects register state directly, updated on the commit edge.

Test Plan:
- Reset, then AW=BASE+8 and W=0xDEADBEEF in the same cycle, BREADY=1 -> BVALID one cycle later with BRESP=00; wr_pulse for one cycle with wr_index=2; regs_out[95:64]=0xDEADBEEF. Read BASE+8 -> RDATA=0xDEADBEEF, RRESP=00.
- W=0x12345678 presented 5 cycles before AW=BASE+4 -> WREADY drops after W is taken; commit one cycle after the AW handshake; reg1=0x12345678. Repeat with AW first and the same result.
- Write to BASE+NUM_REGS*4 and to BASE+2 (misaligned) -> BRESP=10, wr_pulse never asserts, all regs unchanged. Read of BASE+0x100 -> RDATA=0, RRESP=10.
- Hold BREADY=0 for 10 cycles after a write -> BVALID and BRESP stable; AWREADY=WREADY=0 throughout. A second write is accepted only after BREADY=1.
- Write 0xA5A5A5A5 to reg3 committing on the same edge as an AR to reg3 (old value 0x11) -> RDATA=0x11. A second read returns 0xA5A5A5A5.
- Assert reset_n=0 with aw_held=1 and RVALID=1 pending -> all outputs reach reset values immediately. After release no BVALID appears, regs=0, and the ready signals are 1.
